// File: rtl/wb_regfile.sv
// Writeback stage: result mux, 32x32 register file with two async read ports, commit counter.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through on both read ports.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic        MemtoRegW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ALUOutW,
    input  logic [4:0]  WriteRegW,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ResultW,
    output logic [31:0] WbCount
);

    logic [31:0] r_regs [32];
    logic [31:0] r_wb_count;
    logic        w_commit;
    logic        w_byp1;
    logic        w_byp2;

    assign ResultW  = MemtoRegW ? ReadDataW : ALUOutW;
    assign w_commit = RegWriteW && (WriteRegW != 5'd0);
    assign WbCount  = r_wb_count;

    // Entry 0 is never written after reset, so it always reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[WriteRegW] <= ResultW;
            r_wb_count        <= r_wb_count + 32'd1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_commit && (WriteRegW == A1D);
    assign w_byp2 = w_commit && (WriteRegW == A2D);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (A1D != 5'd0) begin
            RD1D = w_byp1 ? ResultW : r_regs[A1D];
        end
        if (A2D != 5'd0) begin
            RD2D = w_byp2 ? ResultW : r_regs[A2D];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile; honours REGFILE_BYPASS_EN if defined.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] WbCount;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .A1D       (A1D),
        .A2D       (A2D),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .ResultW   (ResultW),
        .WbCount   (WbCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] count;
    } exp_t;

    exp_t        q[$];
    int          ntests = 0;
    int          nfail  = 0;

    // Architectural reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ResultW", ResultW, e.result);
            chk("RD1D", RD1D, e.rd1);
            chk("RD2D", RD2D, e.rd2);
            chk("WbCount", WbCount, e.count);
        end
    end

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
        if (Bypass && we && wa == a) return res;
        return m_regs[a];
    endfunction

    // Drive one cycle of W-stage inputs, queue the expected outputs, then advance the model.
    task automatic step(input logic r, input logic we, input logic m2r, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] wa, input logic [4:0] a1,
                        input logic [4:0] a2);
        exp_t        e;
        logic [31:0] res;
        rst = r; RegWriteW = we; MemtoRegW = m2r; ReadDataW = rd; ALUOutW = alu;
        WriteRegW = wa; A1D = a1; A2D = a2;
        res      = m2r ? rd : alu;
        e.result = res;
        e.rd1    = mread(a1, we, wa, res);
        e.rd2    = mread(a2, we, wa, res);
        e.count  = m_count;
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_count = 32'd0;
        end else if (we && wa != 5'd0) begin
            m_regs[wa] = res;
            m_count    = m_count + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0; ReadDataW = '0; ALUOutW = '0;
        WriteRegW = '0; A1D = '0; A2D = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
        @(posedge clk);
        #1;

        // Reset clears stored data
        step(0, 1, 0, 0, 32'hDEADBEEF, 5, 5, 0);
        step(1, 0, 0, 0, 0, 0, 5, 5);
        step(1, 0, 0, 0, 0, 0, 5, 5);
        step(0, 0, 0, 0, 0, 0, 5, 5);

        // Result mux and commit
        step(0, 1, 0, 32'h0, 32'h12345678, 8, 0, 8);
        step(0, 0, 0, 0, 0, 0, 8, 8);
        step(0, 1, 1, 32'hCAFEF00D, 32'h0, 8, 0, 8);
        step(0, 0, 0, 0, 0, 0, 8, 8);

        // $0 protection and disabled write
        step(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        step(0, 1, 0, 0, 32'h00000003, 3, 0, 3);
        step(0, 0, 0, 0, 32'hAAAA0000, 3, 0, 3);
        step(0, 0, 0, 0, 0, 0, 3, 0);

        // Same-cycle read and write to one register
        step(0, 1, 0, 0, 32'h11111111, 9, 0, 0);
        step(0, 1, 0, 0, 32'h22222222, 9, 9, 9);
        step(0, 0, 0, 0, 0, 0, 9, 9);

        // Reset wins over a simultaneous commit
        step(0, 1, 0, 0, 32'h44, 4, 4, 4);
        step(1, 1, 0, 0, 32'h55, 4, 4, 4);
        step(0, 0, 0, 0, 0, 0, 4, 4);

        // Counter wrap via backdoor preload
        dut.r_wb_count = 32'hFFFFFFFF;
        m_count        = 32'hFFFFFFFF;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h77, 7, 7, 0);
        step(0, 0, 0, 0, 0, 0, 7, 0);

        // Random traffic with low register indices favoured to create hits
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), $urandom, $urandom, wa, a1, a2);
        end
        RegWriteW = 1'b0;

        for (int w = 0; w < 5 && q.size() != 0; w++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
